// File: rtl/fft_stream_ctrl.sv
// rtl/fft_stream_ctrl.sv - feed/capture controller wrapping one 16-point pipelined DIF FFT core
// Define FFT_STREAM_DRAIN_EN to enable ghost-frame draining of the core pipeline.
module fft_stream_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data_r,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data_r,
  output logic [DATA_WIDTH-1:0] m_data_i,
  output logic [3:0]            m_index,
  output logic                  m_last,
  output logic                  fft_stall,
  output logic [DATA_WIDTH-1:0] fft_x_r,
  output logic [DATA_WIDTH-1:0] fft_x_i,
  input  logic                  fft_valid_out,
  input  logic [DATA_WIDTH-1:0] fft_X_r,
  input  logic [DATA_WIDTH-1:0] fft_X_i,
  output logic                  busy
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

`ifdef FFT_STREAM_DRAIN_EN
  typedef enum logic [1:0] {S_IDLE, S_REAL, S_GHOST} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_REAL} state_t;
`endif

  state_t                  state, state_nxt, cur;
  logic [3:0]              ph, oi;
  logic [CW-1:0]           fifo_cnt;
  logic [AW-1:0]           fifo_wp, fifo_rp;
  logic [2*DATA_WIDTH-1:0] fifo_mem [OUT_DEPTH];
  logic [1:0]              tag_mem;
  logic                    tag_wp, tag_rp;
  logic [1:0]              tag_cnt;
  logic                    fifo_room, launch_ok, adv;
  logic                    tag_push, tag_pop, cap, fifo_wr, fifo_rd;

`ifdef FFT_STREAM_DRAIN_EN
  logic real_tag_out;
  assign real_tag_out = (tag_cnt != 2'd0 && tag_mem[tag_rp]) ||
                        (tag_cnt == 2'd2 && tag_mem[~tag_rp]);
`endif

  // cur is the frame kind for this cycle; at ph==0 the launch decision is made
  // combinationally so back-to-back frames lose no cycle.
  always_comb begin
    fifo_room = fifo_cnt < CW'(OUT_DEPTH);
    launch_ok = (tag_cnt < 2'd2) && fifo_room;
    cur       = state;
    if (ph == 4'd0) begin
      cur = S_IDLE;
      if (launch_ok && s_valid) cur = S_REAL;
`ifdef FFT_STREAM_DRAIN_EN
      else if (launch_ok && real_tag_out) cur = S_GHOST;
`endif
    end
    if (!rst_n) cur = S_IDLE;

    s_ready = 1'b0;
    adv     = 1'b0;
    fft_x_r = '0;
    fft_x_i = '0;
    case (cur)
      S_REAL: begin
        s_ready = fifo_room;
        adv     = s_valid && fifo_room;
        fft_x_r = s_data_r;
        fft_x_i = s_data_i;
      end
`ifdef FFT_STREAM_DRAIN_EN
      S_GHOST: adv = fifo_room;
`endif
      default: ;
    endcase
    if (ph == 4'd0) s_ready = launch_ok && rst_n;
    fft_stall = !adv;

    tag_push = adv && (ph == 4'd0);
    cap      = adv && fft_valid_out;
    tag_pop  = cap && (oi == 4'd15);
    fifo_wr  = cap && (tag_cnt != 2'd0) && tag_mem[tag_rp];
    fifo_rd  = m_valid && m_ready;

    state_nxt = state;
    if (adv) state_nxt = (ph == 4'd15) ? S_IDLE : cur;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ph       <= 4'd0;
      oi       <= 4'd0;
      m_index  <= 4'd0;
      fifo_cnt <= '0;
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      tag_mem  <= 2'b00;
      tag_wp   <= 1'b0;
      tag_rp   <= 1'b0;
      tag_cnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (adv) ph <= ph + 4'd1;
      if (cap) oi <= oi + 4'd1;
      if (tag_push) begin
        tag_mem[tag_wp] <= (cur == S_REAL);
        tag_wp          <= ~tag_wp;
      end
      if (tag_pop) tag_rp <= ~tag_rp;
      tag_cnt <= tag_cnt + 2'(tag_push) - 2'(tag_pop);
      if (fifo_wr) fifo_wp <= fifo_wp + AW'(1);
      if (fifo_rd) begin
        fifo_rp <= fifo_rp + AW'(1);
        m_index <= m_index + 4'd1;
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[fifo_wp] <= {fft_X_r, fft_X_i};
  end

  always_comb begin
    m_valid              = fifo_cnt != '0;
    {m_data_r, m_data_i} = m_valid ? fifo_mem[fifo_rp] : '0;
    m_last               = m_index == 4'd15;
`ifdef FFT_STREAM_DRAIN_EN
    busy = m_valid || (state == S_REAL) || real_tag_out;
`else
    busy = m_valid || (state == S_REAL);
`endif
  end

  tag_store_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    tag_push |-> (tag_cnt != 2'd2 || tag_pop));

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// tb/tb_fft_stream_ctrl.sv - randomized self-checking bench for fft_stream_ctrl
// The FFT core is stood in for by a 15-advance delay line with a fixed per-sample mix.
`timescale 1ns/1ps
module tb_fft_stream_ctrl;
  localparam int W     = 12;
  localparam int DEPTH = 16;
  localparam int LAT   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, s_valid, s_ready, m_valid, m_ready, m_last;
  logic         fft_stall, fft_valid_out, busy;
  logic [W-1:0] s_data_r, s_data_i, m_data_r, m_data_i;
  logic [W-1:0] fft_x_r, fft_x_i, fft_X_r, fft_X_i;
  logic [3:0]   m_index;

  int n_checks = 0;
  int n_fail   = 0;
  int mr_mode  = 0;

  fft_stream_ctrl #(.DATA_WIDTH(W), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_r(s_data_r), .s_data_i(s_data_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_r(m_data_r), .m_data_i(m_data_i),
    .m_index(m_index), .m_last(m_last),
    .fft_stall(fft_stall), .fft_x_r(fft_x_r), .fft_x_i(fft_x_i),
    .fft_valid_out(fft_valid_out), .fft_X_r(fft_X_r), .fft_X_i(fft_X_i),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] core_fn(input logic [W-1:0] r, input logic [W-1:0] i);
    return {r + i, r - i};
  endfunction

  // core stand-in: output presented after 15 advances, valid once primed
  logic [2*W-1:0] pipe [LAT];
  int core_cnt;
  always @(posedge clk) begin
    if (!rst_n) core_cnt <= 0;
    else if (!fft_stall) begin
      pipe[0] <= {fft_x_r, fft_x_i};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (core_cnt < LAT) core_cnt <= core_cnt + 1;
    end
  end
  assign fft_valid_out = core_cnt >= LAT;
  assign {fft_X_r, fft_X_i} = core_fn(pipe[LAT-1][2*W-1:W], pipe[LAT-1][W-1:0]);

  // reference model: frame kinds in flight, real-output occupancy, expected output order
  logic [2*W-1:0] exp_q[$];
  int kinds[$];
  int b_ph, b_kind, out_in_frame, pending, acc_cnt, rcv_cnt, s_drops;
  bit feed_cont = 0;

  always @(negedge clk) begin : mon
    bit adv, acc, pop, cap, wr, has_real;
    logic [2*W-1:0] e;
    if (!rst_n) begin
      exp_q.delete(); kinds.delete();
      b_ph = 0; b_kind = 0; out_in_frame = 0; pending = 0; acc_cnt = 0; rcv_cnt = 0;
    end else begin
      adv = !fft_stall;
      acc = s_valid && s_ready;
      pop = m_valid && m_ready;
      cap = adv && fft_valid_out;
      check_eq("m_valid_vs_occupancy", m_valid, pending != 0);
      if (b_ph == 0) begin
        has_real = 0;
        foreach (kinds[k]) if (kinds[k] == 1) has_real = 1;
        if (s_valid) check_eq("launch_real", acc && adv, pending < DEPTH && kinds.size() < 2);
        else begin
`ifdef FFT_STREAM_DRAIN_EN
          check_eq("launch_ghost", adv, pending < DEPTH && kinds.size() < 2 && has_real);
`else
          check_eq("idle_stall", fft_stall, 1'b1);
`endif
        end
        if (adv) begin
          b_kind = acc ? 1 : 0;
          kinds.push_back(b_kind);
        end
      end else if (b_kind == 1) begin
        check_eq("real_stall", fft_stall, !(s_valid && pending < DEPTH));
        check_eq("real_s_ready", s_ready, pending < DEPTH);
      end else begin
        check_eq("ghost_stall", fft_stall, pending >= DEPTH);
        check_eq("ghost_s_ready", s_ready, 1'b0);
      end
      if (adv) check_eq("core_input", {fft_x_r, fft_x_i},
                        (b_kind == 1) ? {s_data_r, s_data_i} : 24'd0);
      if (feed_cont && s_valid && !s_ready) s_drops++;
      if (acc) begin
        exp_q.push_back(core_fn(s_data_r, s_data_i));
        acc_cnt++;
      end
      wr = 0;
      if (cap && kinds.size() != 0) begin
        wr = (kinds[0] == 1);
        out_in_frame++;
        if (out_in_frame == 16) begin
          out_in_frame = 0;
          void'(kinds.pop_front());
        end
      end
      if (pop) begin
        check_eq("m_data_expected", exp_q.size() != 0, 1'b1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check_eq("m_data", {m_data_r, m_data_i}, e);
        check_eq("m_index", m_index, rcv_cnt % 16);
        check_eq("m_last", m_last, (rcv_cnt % 16) == 15);
        rcv_cnt++;
      end
      pending = pending + (wr ? 1 : 0) - (pop ? 1 : 0);
      if (adv) b_ph = (b_ph + 1) % 16;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic send_frame(input int nsamp, input int gap_at, input int gap_len, input bit impulse);
    bit ok;
    for (int i = 0; i < nsamp; i++) begin
      if (i == gap_at) begin
        s_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      s_valid  = 1'b1;
      s_data_r = impulse ? ((i == 0) ? 12'h400 : 12'h000) : W'($urandom);
      s_data_i = impulse ? 12'h000 : W'($urandom);
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clk); ok = s_ready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        check_eq("send_timeout", ok, 1'b1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic settle(input string tag);
    s_valid = 1'b0;
    mr_mode = 0;
    repeat (70) @(posedge clk);
    @(negedge clk);
`ifdef FFT_STREAM_DRAIN_EN
    check_eq(tag, rcv_cnt, acc_cnt);
`else
    check_eq(tag, rcv_cnt, (acc_cnt > LAT) ? acc_cnt - LAT : 0);
`endif
    check_eq("busy_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: run exceeded its time bound");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b1; s_data_r = 12'h123; s_data_i = 12'h456;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_fft_stall", fft_stall, 1'b1);
    check_eq("rst_s_ready", s_ready, 1'b0);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_last", m_last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_m_data", {m_data_r, m_data_i}, 24'd0);
    check_eq("rst_fft_x", {fft_x_r, fft_x_i}, 24'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0; s_data_r = '0; s_data_i = '0;

    send_frame(16, -1, 0, 1'b1);
    settle("impulse_count");

    feed_cont = 1; s_drops = 0;
    for (int f = 0; f < 3; f++) send_frame(16, -1, 0, 1'b0);
    feed_cont = 0;
    check_eq("s_ready_drops", s_drops, 0);
    settle("b2b_count");

    send_frame(16, 7, 5, 1'b0);
    settle("gap_count");

    send_frame(16, -1, 0, 1'b0);
    fork
      begin
        send_frame(16, -1, 0, 1'b0);
        send_frame(16, -1, 0, 1'b0);
      end
      begin
        mr_mode = 2;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_eq("stall_when_full", fft_stall, 1'b1);
        check_eq("m_valid_when_full", m_valid, 1'b1);
        @(posedge clk); #1;
        mr_mode = 0;
      end
    join
    settle("backpressure_count");

    mr_mode = 1;
    for (int f = 0; f < 4; f++) send_frame(16, $urandom_range(0, 15), $urandom_range(0, 3), 1'b0);
    settle("random_count");

    mr_mode = 2;
    send_frame(9, -1, 0, 1'b0);
    rst_n = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    check_eq("s_ready_in_reset", s_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0; mr_mode = 0;
    @(negedge clk);
    check_eq("m_valid_after_reset0", m_valid, 1'b0);
    @(negedge clk);
    check_eq("m_valid_after_reset1", m_valid, 1'b0);
    @(posedge clk); #1;
    send_frame(16, -1, 0, 1'b1);
    settle("post_reset_count");
    send_frame(16, -1, 0, 1'b0);
    send_frame(16, 3, 2, 1'b0);
    settle("final_count");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
